byte_loaded_instruction_memory: RTL and testbench
=================================================

# byte_loaded_instruction_memory

Parametrised instruction memory for the MIPS IF stage, loaded one byte at a time from the debug/UART loader instead of one full word at a time. Incoming bytes are assembled into words in a configurable byte order and written sequentially. A multi-cycle clear sweep zeroes the array, and the block reports fill level, full and halt-loaded status. The fetch port is an asynchronous word read addressed by the byte-granular PC.

## Interface
- WORD_SIZE_IN_BYTES, 4, bytes per instruction word; word width W = 8*WORD_SIZE_IN_BYTES.
- MEM_SIZE_IN_WORDS, 64, depth in words; ≥ 2.
- PC_BUS_SIZE, 32, PC width.
- BIG_ENDIAN, 1, 1 = first received byte is the MSB; 0 = first received byte is the LSB.
- HALT_INSTRUCTION, W'hFFFFFFFF, word value flagged as program end.
- CW = $clog2(MEM_SIZE_IN_WORDS+1), count width.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_byte_write  in  1  one-cycle strobe: i_byte is valid this cycle.
- i_byte  in  8  loader data byte.
- i_clear  in  1  request for a full-array clear sweep.
- i_pc  in  PC_BUS_SIZE  fetch byte address.
- o_instruction  out  W  word at i_pc (combinational).
- o_count  out  CW  number of complete words written since the last clear.
- o_full  out  1  o_count == MEM_SIZE_IN_WORDS.
- o_empty  out  1  o_count == 0 and no partial word is pending.
- o_clear_busy  out  1  clear sweep in progress.
- o_halt_loaded  out  1  a completed word equal to HALT_INSTRUCTION has been written since the last clear.

## Operation
- FSM states:
  - CLEAR: writes 0 to mem[sweep_idx] each cycle and increments sweep_idx. After the write to index MEM_SIZE_IN_WORDS-1, moves to LOAD.
  - LOAD: normal operation.
- Reset, while i_reset is high:
  - state = CLEAR, sweep_idx = 0, wr_ptr = 0, byte_cnt = 0, o_count = 0, o_halt_loaded = 0.
  - o_clear_busy = 1, o_full = 0, o_empty = 1.
  - The sweep starts on the first edge with i_reset low.
- Byte assembly (LOAD state, i_byte_write = 1, not full):
  - The byte is placed in the shift register at lane byte_cnt (lane order per BIG_ENDIAN), and byte_cnt increments.
  - On the WORD_SIZE_IN_BYTES-th byte, in the same edge:
    - the full word (including this byte) is written to mem[wr_ptr];
    - wr_ptr and o_count increment; byte_cnt returns to 0;
    - o_halt_loaded is set if the word equals HALT_INSTRUCTION.
- Full: i_byte_write is ignored (byte dropped) and no state changes. The partial-word register is always empty when full.
- Clear request: i_clear = 1 in LOAD state causes:
  - state = CLEAR, sweep_idx = 0, wr_ptr = 0, byte_cnt = 0 (any partial word is discarded);
  - o_count = 0, o_halt_loaded = 0.
- During CLEAR:
  - i_byte_write and i_clear are ignored.
  - o_instruction still reads the array, which may be partially zeroed.
- Priority within one cycle: i_reset > i_clear > i_byte_write. If i_clear and i_byte_write arrive together in LOAD, the byte is dropped.
- Read:
  - Word index = i_pc >> $clog2(WORD_SIZE_IN_BYTES). The low PC bits are ignored, so an unaligned PC reads the containing word.
  - An index ≥ MEM_SIZE_IN_WORDS returns 0.
  - Reads never stall and never depend on the FSM state.
- o_halt_loaded is sticky until the next clear or reset. Words written after the halt word are still accepted.

## Timing
- Write latency: a word completed at edge N is visible on o_instruction (for a matching i_pc) immediately after edge N. o_count, o_full and o_halt_loaded also update at edge N.
- Clear duration: o_clear_busy rises at the edge that samples i_clear (or at reset) and falls exactly MEM_SIZE_IN_WORDS edges after the sweep starts. The first accepted byte is the one presented on the edge after o_clear_busy falls.
- o_empty falls at the edge that accepts the first byte of a word; it is not held until that word completes.
- Read path is purely combinational; there is no pipeline register.
- Sustained throughput: one byte per cycle, i.e. one word every WORD_SIZE_IN_BYTES cycles.

## Test plan
All scenarios use MEM_SIZE_IN_WORDS = 4 and WORD_SIZE_IN_BYTES = 4.

1. Reset, then wait 4 cycles.
   - o_clear_busy is 1 for exactly 4 cycles after reset release.
   - o_empty = 1, o_count = 0.
   - Reading PC 0, 4, 8, 12 returns 0.
2. BIG_ENDIAN = 1, send bytes 12 34 56 78, then AB CD EF 01.
   - PC 0 reads 32'h12345678 and PC 4 reads 32'hABCDEF01.
   - PC 5 also reads 32'hABCDEF01.
   - o_count = 2.
   - Repeat with BIG_ENDIAN = 0: PC 0 reads 32'h78563412.
3. Send 16 bytes, then 4 more bytes AA AA AA AA.
   - o_full = 1 and o_count = 4 after byte 16.
   - The extra bytes are dropped; PC 0..12 keep their values.
   - PC 16 reads 0.
4. Write two words, the second equal to FFFFFFFF.
   - o_halt_loaded rises on the edge of byte 8.
   - Assert i_clear together with an i_byte_write: the byte is dropped, o_clear_busy = 1 for 4 cycles, o_halt_loaded = 0, and all reads return 0 afterwards.
5. Send 2 bytes, assert i_clear, then after the sweep send 11 22 33 44.
   - The partial word is discarded.
   - PC 0 reads 32'h11223344 at wr_ptr 0.
   - Bytes presented while o_clear_busy = 1 are ignored.
6. Assert i_reset mid-load (after 6 bytes).
   - The next edge restarts the sweep: counters and flags return to reset values.
   - After 4 further cycles, all words read 0.

Source files
------------

// File: rtl/byte_loaded_instruction_memory_if.sv
// Loader/fetch bus of the byte-loaded instruction memory.
// The master side is the loader/fetch stage; the slave side is the memory.
interface byte_loaded_instruction_memory_if #(
    parameter int unsigned WORD_SIZE_IN_BYTES = 4,
    parameter int unsigned MEM_SIZE_IN_WORDS  = 64,
    parameter int unsigned PC_BUS_SIZE        = 32
);
    localparam int unsigned W  = 8 * WORD_SIZE_IN_BYTES;
    localparam int unsigned CW = $clog2(MEM_SIZE_IN_WORDS + 1);

    logic                   i_byte_write;
    logic [7:0]             i_byte;
    logic                   i_clear;
    logic [PC_BUS_SIZE-1:0] i_pc;
    logic [W-1:0]           o_instruction;
    logic [CW-1:0]          o_count;
    logic                   o_full;
    logic                   o_empty;
    logic                   o_clear_busy;
    logic                   o_halt_loaded;

    modport master (
        output i_byte_write, i_byte, i_clear, i_pc,
        input  o_instruction, o_count, o_full, o_empty, o_clear_busy, o_halt_loaded
    );

    modport slave (
        input  i_byte_write, i_byte, i_clear, i_pc,
        output o_instruction, o_count, o_full, o_empty, o_clear_busy, o_halt_loaded
    );
endinterface

// File: rtl/byte_loaded_instruction_memory.sv
// Instruction memory for the IF stage, filled one byte at a time by the
// debug/UART loader. Bytes are packed into words in the configured byte
// order and written sequentially; a multi-cycle sweep zeroes the array.
// Fetch is an asynchronous word read addressed by the byte-granular PC.
module byte_loaded_instruction_memory #(
    parameter int unsigned WORD_SIZE_IN_BYTES = 4,
    parameter int unsigned MEM_SIZE_IN_WORDS  = 64,
    parameter int unsigned PC_BUS_SIZE        = 32,
    parameter bit          BIG_ENDIAN         = 1'b1,
    parameter logic [8*WORD_SIZE_IN_BYTES-1:0] HALT_INSTRUCTION = '1
) (
    input  logic i_clk,
    input  logic i_reset,
    byte_loaded_instruction_memory_if.slave bus
);
    localparam int unsigned W     = 8 * WORD_SIZE_IN_BYTES;
    localparam int unsigned CW    = $clog2(MEM_SIZE_IN_WORDS + 1);
    localparam int unsigned IW    = $clog2(MEM_SIZE_IN_WORDS);
    localparam int unsigned BW    = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
    localparam int unsigned SHIFT = $clog2(WORD_SIZE_IN_BYTES);

    localparam logic [CW-1:0]          DEPTH     = CW'(MEM_SIZE_IN_WORDS);
    localparam logic [PC_BUS_SIZE-1:0] DEPTH_PC  = PC_BUS_SIZE'(MEM_SIZE_IN_WORDS);
    localparam logic [IW-1:0]          LAST_IDX  = IW'(MEM_SIZE_IN_WORDS - 1);
    localparam logic [BW-1:0]          LAST_BYTE = BW'(WORD_SIZE_IN_BYTES - 1);

    localparam logic [0:0] ST_LOAD  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [W-1:0]  mem_q [MEM_SIZE_IN_WORDS];

    logic [0:0]    state_q,    state_d;
    logic [IW-1:0] sweep_q,    sweep_d;
    logic [IW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [CW-1:0] count_q,    count_d;
    logic          halt_q,     halt_d;
    logic [W-1:0]  partial_q,  partial_d;

    logic [BW-1:0] lane;
    logic [W-1:0]  word_asm;
    logic          full;
    logic          accept;
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [W-1:0]  mem_wdata;
    logic [PC_BUS_SIZE-1:0] rd_idx;

    assign full   = (count_q == DEPTH);
    assign accept = (state_q == ST_LOAD) && !bus.i_clear && bus.i_byte_write && !full;

    // Merge the incoming byte into the partial word at its byte-order lane
    always_comb begin
        lane     = BIG_ENDIAN ? (LAST_BYTE - byte_cnt_q) : byte_cnt_q;
        word_asm = partial_q;
        for (int unsigned i = 0; i < WORD_SIZE_IN_BYTES; i++) begin
            if (BW'(i) == lane) begin
                word_asm[8*i +: 8] = bus.i_byte;
            end
        end
    end

    // Next-state logic: clear sweep, clear request, byte assembly and word commit
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        wr_ptr_d   = wr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        count_d    = count_q;
        halt_d     = halt_q;
        partial_d  = partial_q;
        mem_we     = 1'b0;
        mem_waddr  = sweep_q;
        mem_wdata  = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = '0;
                sweep_d   = sweep_q + IW'(1);
                if (sweep_q == LAST_IDX) begin
                    state_d = ST_LOAD;
                    sweep_d = '0;
                end
            end
            default: begin
                if (bus.i_clear) begin
                    state_d    = ST_CLEAR;
                    sweep_d    = '0;
                    wr_ptr_d   = '0;
                    byte_cnt_d = '0;
                    count_d    = '0;
                    halt_d     = 1'b0;
                    partial_d  = '0;
                end else if (accept) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        mem_we     = 1'b1;
                        mem_waddr  = wr_ptr_q;
                        mem_wdata  = word_asm;
                        wr_ptr_d   = wr_ptr_q + IW'(1);
                        count_d    = count_q + CW'(1);
                        byte_cnt_d = '0;
                        partial_d  = '0;
                        if (word_asm == HALT_INSTRUCTION) begin
                            halt_d = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                        partial_d  = word_asm;
                    end
                end
            end
        endcase
    end

    // Control registers; reset parks the block at the start of a clear sweep
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_CLEAR;
            sweep_q    <= '0;
            wr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            count_q    <= '0;
            halt_q     <= 1'b0;
            partial_q  <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            wr_ptr_q   <= wr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            count_q    <= count_d;
            halt_q     <= halt_d;
            partial_q  <= partial_d;
        end
    end

    // Storage array; zeroing is done by the sweep rather than by reset
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Asynchronous fetch; out-of-range word indices read as zero
    always_comb begin
        rd_idx = bus.i_pc >> SHIFT;
        if (rd_idx < DEPTH_PC) begin
            bus.o_instruction = mem_q[rd_idx[IW-1:0]];
        end else begin
            bus.o_instruction = '0;
        end
    end

    assign bus.o_count       = count_q;
    assign bus.o_full        = full;
    assign bus.o_empty       = (count_q == '0) && (byte_cnt_q == '0);
    assign bus.o_clear_busy  = (state_q == ST_CLEAR);
    assign bus.o_halt_loaded = halt_q;
endmodule

// File: tb/tb_byte_loaded_instruction_memory.sv
// Scoreboard bench for byte_loaded_instruction_memory: a big-endian and a
// little-endian instance share all stimulus; expectations are queued by the
// stimulus process and checked by a monitor on the falling clock edge.
module tb_byte_loaded_instruction_memory;
    localparam int unsigned F_INSTR = 0;
    localparam int unsigned F_COUNT = 1;
    localparam int unsigned F_FULL  = 2;
    localparam int unsigned F_EMPTY = 3;
    localparam int unsigned F_BUSY  = 4;
    localparam int unsigned F_HALT  = 5;

    typedef struct {
        string       name;
        int unsigned fld;
        logic [31:0] exp;
        bit          le;
    } chk_t;

    chk_t sbq[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bw  = 1'b0;
    logic [7:0]  bb  = 8'h00;
    logic        clr = 1'b0;
    logic [31:0] pc  = 32'h0;

    always #5 clk = ~clk;

    byte_loaded_instruction_memory_if #(.WORD_SIZE_IN_BYTES(4), .MEM_SIZE_IN_WORDS(4), .PC_BUS_SIZE(32)) ifb ();
    byte_loaded_instruction_memory_if #(.WORD_SIZE_IN_BYTES(4), .MEM_SIZE_IN_WORDS(4), .PC_BUS_SIZE(32)) ifl ();

    assign ifb.i_byte_write = bw;
    assign ifb.i_byte       = bb;
    assign ifb.i_clear      = clr;
    assign ifb.i_pc         = pc;
    assign ifl.i_byte_write = bw;
    assign ifl.i_byte       = bb;
    assign ifl.i_clear      = clr;
    assign ifl.i_pc         = pc;

    byte_loaded_instruction_memory #(
        .WORD_SIZE_IN_BYTES(4), .MEM_SIZE_IN_WORDS(4), .PC_BUS_SIZE(32),
        .BIG_ENDIAN(1'b1), .HALT_INSTRUCTION(32'hFFFFFFFF)
    ) dut_be (
        .i_clk(clk), .i_reset(rst), .bus(ifb)
    );

    byte_loaded_instruction_memory #(
        .WORD_SIZE_IN_BYTES(4), .MEM_SIZE_IN_WORDS(4), .PC_BUS_SIZE(32),
        .BIG_ENDIAN(1'b0), .HALT_INSTRUCTION(32'hFFFFFFFF)
    ) dut_le (
        .i_clk(clk), .i_reset(rst), .bus(ifl)
    );

    function automatic logic [31:0] observe(int unsigned f, bit le);
        case (f)
            F_INSTR: return le ? ifl.o_instruction : ifb.o_instruction;
            F_COUNT: return le ? 32'(ifl.o_count) : 32'(ifb.o_count);
            F_FULL:  return le ? 32'(ifl.o_full) : 32'(ifb.o_full);
            F_EMPTY: return le ? 32'(ifl.o_empty) : 32'(ifb.o_empty);
            F_BUSY:  return le ? 32'(ifl.o_clear_busy) : 32'(ifb.o_clear_busy);
            default: return le ? 32'(ifl.o_halt_loaded) : 32'(ifb.o_halt_loaded);
        endcase
    endfunction

    // Monitor: compare every queued expectation against the DUT on the falling edge
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        while (sbq.size() > 0) begin
            c   = sbq.pop_front();
            act = observe(c.fld, c.le);
            n_vec++;
            if (act !== c.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string nm, input int unsigned f, input logic [31:0] e);
        sbq.push_back('{nm, f, e, 1'b0});
    endtask

    task automatic expect_rd(input string nm, input logic [31:0] p, input logic [31:0] e, input bit le);
        pc = p;
        sbq.push_back('{nm, F_INSTR, e, le});
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bw = 1'b1;
        bb = b;
        tick();
        bw = 1'b0;
    endtask

    // Called just after the edge that entered the sweep: busy for 4 cycles
    task automatic sweep_check(input string nm);
        expect_st({nm, "_busy0"}, F_BUSY, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            expect_st($sformatf("%s_busy%0d", nm, k), F_BUSY, 32'd1);
        end
        tick();
        expect_st({nm, "_busy_end"}, F_BUSY, 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        for (int a = 0; a < 16; a += 4) begin
            expect_rd($sformatf("%s_pc%0d", nm, a), 32'(a), 32'h0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // 1: reset and initial sweep
        rst = 1'b1;
        tick();
        tick();
        expect_st("rst_busy",  F_BUSY,  32'd1);
        expect_st("rst_empty", F_EMPTY, 32'd1);
        expect_st("rst_count", F_COUNT, 32'd0);
        expect_st("rst_full",  F_FULL,  32'd0);
        expect_st("rst_halt",  F_HALT,  32'd0);
        rst = 1'b0;
        sweep_check("init");
        expect_st("init_empty", F_EMPTY, 32'd1);
        expect_st("init_count", F_COUNT, 32'd0);
        check_all_zero("init");

        // 2: byte order
        send(8'h12); expect_st("first_byte_empty", F_EMPTY, 32'd0);
        send(8'h34); send(8'h56); send(8'h78);
        send(8'hAB); send(8'hCD); send(8'hEF); send(8'h01);
        expect_st("two_words_count", F_COUNT, 32'd2);
        expect_rd("be_pc0", 32'd0, 32'h12345678, 1'b0);
        expect_rd("be_pc4", 32'd4, 32'hABCDEF01, 1'b0);
        expect_rd("be_pc5", 32'd5, 32'hABCDEF01, 1'b0);
        expect_rd("le_pc0", 32'd0, 32'h78563412, 1'b1);
        expect_rd("le_pc4", 32'd4, 32'h01EFCDAB, 1'b1);

        // 3: fill to full, then overflow bytes are dropped
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        expect_st("full_flag",  F_FULL,  32'd1);
        expect_st("full_count", F_COUNT, 32'd4);
        for (int i = 0; i < 4; i++) send(8'hAA);
        expect_st("ovf_count", F_COUNT, 32'd4);
        expect_st("ovf_full",  F_FULL,  32'd1);
        expect_st("ovf_halt",  F_HALT,  32'd0);
        expect_rd("ovf_pc0",  32'd0,  32'h12345678, 1'b0);
        expect_rd("ovf_pc8",  32'd8,  32'h11223344, 1'b0);
        expect_rd("ovf_pc12", 32'd12, 32'h55667788, 1'b0);
        expect_rd("ovf_pc16", 32'd16, 32'h00000000, 1'b0);

        // 4: halt detection, then clear colliding with a byte write
        clr = 1'b1;
        tick();
        clr = 1'b0;
        expect_st("clr1_count", F_COUNT, 32'd0);
        sweep_check("clr1");
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hFF); send(8'hFF); send(8'hFF);
        expect_st("halt_before", F_HALT, 32'd0);
        send(8'hFF);
        expect_st("halt_after",  F_HALT,  32'd1);
        expect_st("halt_count",  F_COUNT, 32'd2);
        clr = 1'b1;
        bw  = 1'b1;
        bb  = 8'h5A;
        tick();
        clr = 1'b0;
        bw  = 1'b0;
        expect_st("clr2_halt",  F_HALT,  32'd0);
        expect_st("clr2_count", F_COUNT, 32'd0);
        expect_st("clr2_empty", F_EMPTY, 32'd1);
        sweep_check("clr2");
        check_all_zero("clr2");

        // 5: partial word discarded, bytes during sweep ignored
        send(8'hDE); send(8'hAD);
        expect_st("partial_empty", F_EMPTY, 32'd0);
        expect_st("partial_count", F_COUNT, 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bw  = 1'b1;
        bb  = 8'h99;
        sweep_check("clr3");
        bw  = 1'b0;
        expect_st("clr3_count", F_COUNT, 32'd0);
        expect_st("clr3_empty", F_EMPTY, 32'd1);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        expect_st("after_clr3_count", F_COUNT, 32'd1);
        expect_rd("after_clr3_pc0", 32'd0, 32'h11223344, 1'b0);

        // 6: reset in the middle of loading
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        send(8'hC5); send(8'hC6);
        expect_st("midload_count", F_COUNT, 32'd2);
        rst = 1'b1;
        tick();
        expect_st("rst2_count", F_COUNT, 32'd0);
        expect_st("rst2_empty", F_EMPTY, 32'd1);
        expect_st("rst2_full",  F_FULL,  32'd0);
        expect_st("rst2_halt",  F_HALT,  32'd0);
        rst = 1'b0;
        sweep_check("rst2");
        check_all_zero("rst2");

        tick();
        tick();
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
